// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline stall/flush control.
//   state_t : FSM encoding for hazard_stall_unit
//   REG_AW  : register address width
//   X0      : architectural zero register address
package hazard_pkg;

  localparam int unsigned REG_AW = 5;
  localparam logic [4:0]  X0     = 5'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

endpackage

// File: rtl/hazard_wait_timer.sv
// hazard_wait_timer: counts data-memory wait cycles and flags the cycle on
// which the wait has reached MEM_TIMEOUT without a ready response.
//   clk, rst  : clock, synchronous active-high reset
//   start     : first stalled cycle (seen in RUN); loads the count with 1
//   hold      : memory still not ready while waiting; advances the count
//   wait_cnt  : current wait-cycle count
//   timeout   : hold asserted while wait_cnt == MEM_TIMEOUT
module hazard_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             hold,
  output logic [CNT_W-1:0] wait_cnt,
  output logic             timeout
);

  assign timeout = hold && (wait_cnt == CNT_W'(MEM_TIMEOUT));

  // Any cycle that is neither a start nor a continuing wait returns the
  // count to zero, so a released or abandoned wait never leaves residue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (start) begin
      wait_cnt <= CNT_W'(1);
    end else if (hold && !timeout) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: stall/flush control for the 5-stage pipeline. Covers the
// hazards bypassing cannot: load-use bubble, taken-branch squash, and
// freezing while data memory is not ready, with a sticky timeout error.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   rs1_ID, rs2_ID, rs*_used_ID    source operands of the ID instruction
//   rd_EX, MemRead_EX, RegWrite_EX EX instruction destination / kind
//   branch_taken_EX                EX redirects the PC
//   dmem_req_MEM, dmem_ready       data memory handshake in MEM
//   pc_en, *_en, *_flush           PC and pipeline-register controls
//   mem_timeout                    sticky memory-timeout error
//   perf_stall_cnt, perf_flush_cnt performance counters
//
// Build option: HAZARD_PERF_CNT_EN enables the two performance counters;
// without it both perf ports are tied to zero.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | normal issue; load-use / branch / memory-stall decoding
// MEM_WAIT | data memory outstanding; pipeline frozen until dmem_ready
// ERR      | memory wait exceeded MEM_TIMEOUT; frozen until rst
module hazard_stall_unit #(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_ID,
  input  logic [REG_AW-1:0] rs2_ID,
  input  logic              rs1_used_ID,
  input  logic              rs2_used_ID,
  input  logic [REG_AW-1:0] rd_EX,
  input  logic              MemRead_EX,
  input  logic              RegWrite_EX,
  input  logic              branch_taken_EX,
  input  logic              dmem_req_MEM,
  input  logic              dmem_ready,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_ex_en,
  output logic              id_ex_flush,
  output logic              ex_mem_en,
  output logic              mem_wb_flush,
  output logic              mem_timeout,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
);

  import hazard_pkg::*;

  state_t           state, state_next;
  logic             load_use;
  logic             mem_stall_req;
  logic             timer_start;
  logic             timer_hold;
  logic             timer_timeout;
  logic [CNT_W-1:0] wait_cnt;

  assign load_use = MemRead_EX && RegWrite_EX && (rd_EX != REG_AW'(X0)) &&
                    ((rs1_used_ID && (rs1_ID == rd_EX)) ||
                     (rs2_used_ID && (rs2_ID == rd_EX)));

  assign mem_stall_req = dmem_req_MEM && !dmem_ready;
  assign timer_start   = (state == RUN) && mem_stall_req;
  assign timer_hold    = (state == MEM_WAIT) && !dmem_ready;

  hazard_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .start    (timer_start),
    .hold     (timer_hold),
    .wait_cnt (wait_cnt),
    .timeout  (timer_timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b1;
    mem_wb_flush = 1'b0;
    mem_timeout  = 1'b0;

    if (rst) begin
      state_next   = RUN;
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end else begin
      unique case (state)
        RUN, MEM_WAIT: begin
          // The release cycle of a wait is decoded exactly like RUN, so a
          // branch or load-use held during the freeze takes effect here.
          if ((state == RUN) ? mem_stall_req : !dmem_ready) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
            if (state == RUN) begin
              state_next = MEM_WAIT;
            end else if (timer_timeout) begin
              state_next = ERR;
            end
          end else begin
            state_next = RUN;
            if (branch_taken_EX) begin
              // The ID instruction is squashed, so a load-use on it is moot.
              if_id_flush = 1'b1;
              id_ex_flush = 1'b1;
            end else if (load_use) begin
              pc_en       = 1'b0;
              if_id_en    = 1'b0;
              id_ex_flush = 1'b1;
            end
          end
        end
        ERR: begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_en     = 1'b0;
          ex_mem_en    = 1'b0;
          mem_wb_flush = 1'b1;
          mem_timeout  = 1'b1;
        end
        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_en) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (if_id_flush) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

  // Output vector order: pc_en, if_id_en, if_id_flush, id_ex_en,
  // id_ex_flush, ex_mem_en, mem_wb_flush, mem_timeout
  localparam logic [7:0] O_NORMAL = 8'hD4;
  localparam logic [7:0] O_RESET  = 8'h2A;
  localparam logic [7:0] O_LU     = 8'h1C;
  localparam logic [7:0] O_BR     = 8'hFC;
  localparam logic [7:0] O_FREEZE = 8'h02;
  localparam logic [7:0] O_ERR    = 8'h03;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_ID, rs2_ID, rd_EX;
  logic       rs1_used_ID, rs2_used_ID, MemRead_EX, RegWrite_EX;
  logic       branch_taken_EX, dmem_req_MEM, dmem_ready;
  logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic       ex_mem_en, mem_wb_flush, mem_timeout;
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
  logic [7:0] obs;

  int tests_run = 0;
  int tests_failed = 0;

  assign obs = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                ex_mem_en, mem_wb_flush, mem_timeout};

  always #5 clk = ~clk;

  hazard_stall_unit #(.REG_AW(5), .MEM_TIMEOUT(15), .CNT_W(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .rs1_ID          (rs1_ID),
    .rs2_ID          (rs2_ID),
    .rs1_used_ID     (rs1_used_ID),
    .rs2_used_ID     (rs2_used_ID),
    .rd_EX           (rd_EX),
    .MemRead_EX      (MemRead_EX),
    .RegWrite_EX     (RegWrite_EX),
    .branch_taken_EX (branch_taken_EX),
    .dmem_req_MEM    (dmem_req_MEM),
    .dmem_ready      (dmem_ready),
    .pc_en           (pc_en),
    .if_id_en        (if_id_en),
    .if_id_flush     (if_id_flush),
    .id_ex_en        (id_ex_en),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_en       (ex_mem_en),
    .mem_wb_flush    (mem_wb_flush),
    .mem_timeout     (mem_timeout),
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_flush_cnt  (perf_flush_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic quiet;
    rs1_ID = 5'd0; rs2_ID = 5'd0; rd_EX = 5'd0;
    rs1_used_ID = 1'b0; rs2_used_ID = 1'b0;
    MemRead_EX = 1'b0; RegWrite_EX = 1'b0;
    branch_taken_EX = 1'b0; dmem_req_MEM = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic do_reset;
    quiet();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [4:0] r1, input logic u1,
                          input logic [4:0] r2, input logic u2);
    MemRead_EX = 1'b1; RegWrite_EX = 1'b1; rd_EX = rd;
    rs1_ID = r1; rs1_used_ID = u1; rs2_ID = r2; rs2_used_ID = u2;
  endtask

  task automatic test_reset;
    quiet();
    rst = 1'b1;
    #1;
    tests_run++;
    if (obs !== O_RESET) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h expected %h", obs, O_RESET);
    end
    tick();
    tests_run++;
    if (dut.state !== 2'd0 || dut.wait_cnt !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_state: state %0d cnt %0d expected 0 0", dut.state, dut.wait_cnt);
    end
    tests_run++;
    if (perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_perf: stall %0d flush %0d expected 0 0", perf_stall_cnt, perf_flush_cnt);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (obs !== O_NORMAL) begin
      tests_failed++;
      $display("FAIL idle_after_reset: got %h expected %h", obs, O_NORMAL);
    end
  endtask

  task automatic test_load_use;
    do_reset();
    set_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    #1;
    tests_run++;
    if (obs !== O_LU) begin
      tests_failed++;
      $display("FAIL lu_rs1: got %h expected %h", obs, O_LU);
    end
    tick();
    quiet();  // bubble now occupies EX
    #1;
    tests_run++;
    if (obs !== O_NORMAL) begin
      tests_failed++;
      $display("FAIL lu_release: got %h expected %h", obs, O_NORMAL);
    end
    set_load(5'd7, 5'd1, 1'b1, 5'd7, 1'b1);
    #1;
    tests_run++;
    if (obs !== O_LU) begin
      tests_failed++;
      $display("FAIL lu_rs2: got %h expected %h", obs, O_LU);
    end
    tick();
    set_load(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    #1;
    tests_run++;
    if (obs !== O_NORMAL) begin
      tests_failed++;
      $display("FAIL lu_x0: got %h expected %h", obs, O_NORMAL);
    end
    set_load(5'd5, 5'd5, 1'b0, 5'd5, 1'b0);
    #1;
    tests_run++;
    if (obs !== O_NORMAL) begin
      tests_failed++;
      $display("FAIL lu_unused_src: got %h expected %h", obs, O_NORMAL);
    end
    set_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    RegWrite_EX = 1'b0;
    #1;
    tests_run++;
    if (obs !== O_NORMAL) begin
      tests_failed++;
      $display("FAIL lu_no_regwrite: got %h expected %h", obs, O_NORMAL);
    end
    tick();
  endtask

  task automatic test_branch_lu;
    do_reset();
    set_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    branch_taken_EX = 1'b1;
    #1;
    tests_run++;
    if (obs !== O_BR) begin
      tests_failed++;
      $display("FAIL branch_over_lu: got %h expected %h", obs, O_BR);
    end
    tick();
    quiet();
    #1;
    tests_run++;
    if (obs !== O_NORMAL || perf_stall_cnt !== 32'd0) begin
      tests_failed++;
      $display("FAIL branch_after: got %h stall %0d expected %h 0", obs, perf_stall_cnt, O_NORMAL);
    end
    tests_run++;
`ifdef HAZARD_PERF_CNT_EN
    if (perf_flush_cnt !== 32'd1) begin
      tests_failed++;
      $display("FAIL perf_flush: got %0d expected 1", perf_flush_cnt);
    end
`else
    if (perf_flush_cnt !== 32'd0) begin
      tests_failed++;
      $display("FAIL perf_flush: got %0d expected 0", perf_flush_cnt);
    end
`endif
  endtask

  task automatic test_mem_wait;
    do_reset();
    dmem_req_MEM = 1'b1;
    dmem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests_run++;
      if (obs !== O_FREEZE || dut.wait_cnt !== 4'(k)) begin
        tests_failed++;
        $display("FAIL mem_wait_frozen[%0d]: got %h cnt %0d expected %h cnt %0d",
                 k, obs, dut.wait_cnt, O_FREEZE, k);
      end
      tick();
    end
    dmem_ready = 1'b1;
    #1;
    tests_run++;
    if (obs !== O_NORMAL) begin
      tests_failed++;
      $display("FAIL mem_wait_release: got %h expected %h", obs, O_NORMAL);
    end
    tick();
    quiet();
    #1;
    tests_run++;
    if (dut.state !== 2'd0 || dut.wait_cnt !== 4'd0) begin
      tests_failed++;
      $display("FAIL mem_wait_back_to_run: state %0d cnt %0d expected 0 0", dut.state, dut.wait_cnt);
    end
    tests_run++;
`ifdef HAZARD_PERF_CNT_EN
    if (perf_stall_cnt !== 32'd3) begin
      tests_failed++;
      $display("FAIL perf_stall: got %0d expected 3", perf_stall_cnt);
    end
`else
    if (perf_stall_cnt !== 32'd0) begin
      tests_failed++;
      $display("FAIL perf_stall: got %0d expected 0", perf_stall_cnt);
    end
`endif
  endtask

  task automatic test_first_cycle_ready;
    do_reset();
    dmem_req_MEM = 1'b1;
    dmem_ready = 1'b1;
    #1;
    tests_run++;
    if (obs !== O_NORMAL) begin
      tests_failed++;
      $display("FAIL ready_first_cycle: got %h expected %h", obs, O_NORMAL);
    end
    tick();
    tests_run++;
    if (dut.state !== 2'd0) begin
      tests_failed++;
      $display("FAIL ready_first_state: got %0d expected 0", dut.state);
    end
    quiet();
  endtask

  task automatic test_timeout;
    do_reset();
    dmem_req_MEM = 1'b1;
    dmem_ready = 1'b0;
    tick();  // RUN stall cycle, wait_cnt becomes 1
    for (int k = 1; k <= 15; k++) begin
      #1;
      tests_run++;
      if (obs !== O_FREEZE || dut.state !== 2'd1 || dut.wait_cnt !== 4'(k)) begin
        tests_failed++;
        $display("FAIL timeout_wait[%0d]: got %h state %0d cnt %0d expected %h 1 %0d",
                 k, obs, dut.state, dut.wait_cnt, O_FREEZE, k);
      end
      tick();
    end
    quiet();
    dmem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests_run++;
      if (obs !== O_ERR) begin
        tests_failed++;
        $display("FAIL timeout_err[%0d]: got %h expected %h", k, obs, O_ERR);
      end
      tick();
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (obs !== O_RESET) begin
      tests_failed++;
      $display("FAIL err_reset_outputs: got %h expected %h", obs, O_RESET);
    end
    tick();
    rst = 1'b0;
    quiet();
    #1;
    tests_run++;
    if (obs !== O_NORMAL) begin
      tests_failed++;
      $display("FAIL err_cleared: got %h expected %h", obs, O_NORMAL);
    end
  endtask

  task automatic test_timeout_ready_wins;
    do_reset();
    dmem_req_MEM = 1'b1;
    dmem_ready = 1'b0;
    for (int k = 0; k < 15; k++) tick();  // RUN stall + wait_cnt 1..14
    dmem_ready = 1'b1;
    #1;
    tests_run++;
    if (obs !== O_NORMAL || dut.wait_cnt !== 4'd15) begin
      tests_failed++;
      $display("FAIL ready_on_limit: got %h cnt %0d expected %h 15", obs, dut.wait_cnt, O_NORMAL);
    end
    tick();
    quiet();
    #1;
    tests_run++;
    if (dut.state !== 2'd0 || mem_timeout !== 1'b0 || obs !== O_NORMAL) begin
      tests_failed++;
      $display("FAIL ready_on_limit_after: state %0d obs %h expected 0 %h", dut.state, obs, O_NORMAL);
    end
  endtask

  task automatic test_branch_during_wait;
    do_reset();
    branch_taken_EX = 1'b1;
    dmem_req_MEM = 1'b1;
    dmem_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      tests_run++;
      if (obs !== O_FREEZE) begin
        tests_failed++;
        $display("FAIL br_wait_frozen[%0d]: got %h expected %h", k, obs, O_FREEZE);
      end
      tick();
    end
    dmem_ready = 1'b1;
    #1;
    tests_run++;
    if (obs !== O_BR) begin
      tests_failed++;
      $display("FAIL br_wait_release: got %h expected %h", obs, O_BR);
    end
    tick();
    quiet();
    #1;
    tests_run++;
    if (obs !== O_NORMAL) begin
      tests_failed++;
      $display("FAIL br_wait_after: got %h expected %h", obs, O_NORMAL);
    end
  endtask

  task automatic test_reset_mid_wait;
    do_reset();
    dmem_req_MEM = 1'b1;
    dmem_ready = 1'b0;
    tick();
    tick();  // second MEM_WAIT cycle
    rst = 1'b1;
    #1;
    tests_run++;
    if (obs !== O_RESET) begin
      tests_failed++;
      $display("FAIL mid_wait_rst_outputs: got %h expected %h", obs, O_RESET);
    end
    tick();
    rst = 1'b0;
    quiet();
    #1;
    tests_run++;
    if (dut.state !== 2'd0 || dut.wait_cnt !== 4'd0 || obs !== O_NORMAL) begin
      tests_failed++;
      $display("FAIL mid_wait_rst: state %0d cnt %0d obs %h expected 0 0 %h",
               dut.state, dut.wait_cnt, obs, O_NORMAL);
    end
  endtask

  initial begin
    quiet();
    rst = 1'b1;
    tick();
    test_reset();
    test_load_use();
    test_branch_lu();
    test_mem_wait();
    test_first_cycle_ready();
    test_timeout();
    test_timeout_ready_wins();
    test_branch_during_wait();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Stall/flush control that complements the forwarding unit in the 5-stage RISC-V pipeline.
- Forwarding resolves a hazard by bypassing data. This block handles every case bypassing cannot cover:
  - load-use bubble;
  - taken-branch squash;
  - freezing the pipeline while data memory is not ready.
- Drives the PC enable and the per-stage pipeline-register enables and flushes.
- Owns a wait-cycle counter and a sticky timeout error state.

Parameters:
- REG_AW, 5, register address width
- MEM_TIMEOUT, 15, maximum dmem wait cycles before error (1..2^CNT_W-1)
- CNT_W, 4, wait-counter width

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- rs1_ID  in  REG_AW  rs1 of instruction in ID
- rs2_ID  in  REG_AW  rs2 of instruction in ID
- rs1_used_ID  in  1  ID instruction reads rs1
- rs2_used_ID  in  1  ID instruction reads rs2
- rd_EX  in  REG_AW  destination of instruction in EX
- MemRead_EX  in  1  EX instruction is a load
- RegWrite_EX  in  1  EX instruction writes rd
- branch_taken_EX  in  1  EX branch/jump redirects PC
- dmem_req_MEM  in  1  MEM stage accessing data memory
- dmem_ready  in  1  data memory completes this cycle
- pc_en  out  1  PC register update enable
- if_id_en  out  1  IF/ID register enable
- if_id_flush  out  1  IF/ID cleared to NOP
- id_ex_en  out  1  ID/EX register enable
- id_ex_flush  out  1  ID/EX cleared to bubble
- ex_mem_en  out  1  EX/MEM register enable
- mem_wb_flush  out  1  bubble inserted into MEM/WB
- mem_timeout  out  1  sticky memory-timeout error
- perf_stall_cnt  out  32  stall-cycle count (feature only)
- perf_flush_cnt  out  32  branch-flush count (feature only)

Behaviour:
- States (registered, package enum): RUN, MEM_WAIT, ERR.
- Reset:
  - state=RUN, wait_cnt=0;
  - while rst=1, all *_en=0, if_id_flush=id_ex_flush=mem_wb_flush=1, mem_timeout=0, perf counters=0.
- Outputs are combinational from state and inputs, with zero added latency.
  - Default (no hazard): all *_en=1, all flushes=0.
- Load-use:
  - Condition: lu = MemRead_EX & RegWrite_EX & (rd_EX!=0) & ((rs1_used_ID & rs1_ID==rd_EX) | (rs2_used_ID & rs2_ID==rd_EX)).
  - In RUN: pc_en=0, if_id_en=0, id_ex_flush=1.
  - Lasts exactly one cycle, because the bubble in EX clears lu next cycle; forwarding from MEM then covers the operand.
  - rd=x0 never stalls.
- Branch:
  - In RUN with branch_taken_EX=1: pc_en=1, if_id_flush=1, id_ex_flush=1.
  - Branch overrides lu, since the ID instruction is squashed anyway.
- Memory wait:
  - In RUN with dmem_req_MEM & !dmem_ready, in the same cycle: pc_en=if_id_en=id_ex_en=ex_mem_en=0, mem_wb_flush=1, all other flushes=0. Next state MEM_WAIT, wait_cnt=1.
  - Memory wait overrides branch and lu. A branch held in EX takes effect on the release cycle.
- MEM_WAIT:
  - Outputs are frozen as above while dmem_ready=0; wait_cnt increments each cycle.
  - dmem_ready=1 releases: outputs are evaluated exactly as in RUN (lu/branch apply), next state RUN, wait_cnt=0.
  - If wait_cnt==MEM_TIMEOUT with dmem_ready=0, next state is ERR.
  - dmem_ready on the timeout cycle wins, so no error is raised.
- ERR:
  - All enables 0, mem_wb_flush=1, mem_timeout=1.
  - Held until rst.
- A ready response on the first request cycle produces no stall and no state change.
- rst in any state returns to RUN next edge; an in-flight wait is abandoned.

Optional Feature:
- HAZARD_PERF_CNT_EN defined:
  - perf_stall_cnt increments on every non-reset cycle with pc_en=0;
  - perf_flush_cnt increments on every cycle with if_id_flush=1 outside reset;
  - both wrap at 2^32, cleared by rst.
- Undefined: both ports tied to 0, no counter flops.

Decomposition:
- Package hazard_pkg holds:
  - state enum (RUN=2'd0, MEM_WAIT=2'd1, ERR=2'd2);
  - REG_AW;
  - localparam X0=5'd0.
- One natural sub-module, hazard_wait_timer: wait_cnt, compare against MEM_TIMEOUT, and timeout pulse.

Test Plan:
- Load-use: lw x5 in EX (MemRead_EX=1, RegWrite_EX=1, rd_EX=5), ID rs1=5, rs1_used=1 -> one cycle pc_en=0, if_id_en=0, id_ex_flush=1; next cycle all enables 1. Repeat with rd_EX=0 -> no stall.
- Branch plus lu conflict: branch_taken_EX=1 with lu true -> pc_en=1, if_id_flush=1, id_ex_flush=1, if_id_en=1.
- Memory wait: dmem_req_MEM=1, dmem_ready low for 3 cycles then high -> 3 cycles with ex_mem_en=0 and mem_wb_flush=1; release cycle all en=1; perf_stall_cnt=3 when enabled.
- Timeout: ready held low 15 cycles -> ERR, mem_timeout=1, all enables 0 until rst. ready high on the 15th cycle -> RUN, mem_timeout=0.
- Branch during wait: branch_taken_EX=1 throughout a 2-cycle wait -> flushes 0 while frozen; if_id_flush=1 on the release cycle only.
- Reset mid-wait: rst on the 2nd MEM_WAIT cycle -> next cycle state RUN, wait_cnt=0, all enables 1 with quiet inputs.
